// File: rtl/reg_dff_sclr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dff_sclr_pkg
//  Description : Shared project constants for the reset/clear data register.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_dff_sclr_pkg;

    localparam int unsigned c_default_width = 8;

    // Both defaults are all zeros; they are sized to the default width and
    // zero-extended where a wider register is instantiated.
    localparam logic [c_default_width-1:0] c_default_rst_val = '0;
    localparam logic [c_default_width-1:0] c_default_clr_val = '0;

endpackage : reg_dff_sclr_pkg
`default_nettype wire

// File: rtl/reg_dff_sclr.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dff_sclr
//  Description : MAX_WIDTH-bit register with synchronous reset, synchronous
//                clear and load enable (priority rst > sclr > en > hold).
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_dff_sclr
    import reg_dff_sclr_pkg::*;
#(
    parameter int unsigned            MAX_WIDTH = c_default_width,
    parameter logic [MAX_WIDTH-1:0]   RST_VAL   = MAX_WIDTH'(c_default_rst_val),
    parameter logic [MAX_WIDTH-1:0]   CLR_VAL   = MAX_WIDTH'(c_default_clr_val)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sclr,
    input  logic [MAX_WIDTH-1:0] d,
    output logic [MAX_WIDTH-1:0] q
);

    logic [MAX_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (sclr) begin
            r_q <= CLR_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    // Output comes straight from the flops; no input reaches q combinationally.
    assign q = r_q;

endmodule : reg_dff_sclr
`default_nettype wire

// File: tb/tb_reg_dff_sclr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_dff_sclr
//  Description : Directed self-checking bench for reg_dff_sclr (default and
//                non-zero reset/clear value instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dff_sclr;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sclr;
    logic [7:0] d;
    logic [7:0] q_def;
    logic [7:0] q_alt;

    int n_compared;
    int n_mismatched;

    reg_dff_sclr u_dut_def (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .sclr (sclr),
        .d    (d),
        .q    (q_def)
    );

    reg_dff_sclr #(
        .MAX_WIDTH (8),
        .RST_VAL   (8'hA5),
        .CLR_VAL   (8'h5A)
    ) u_dut_alt (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .sclr (sclr),
        .d    (d),
        .q    (q_alt)
    );

    // 50 ns period, rising edges at 25, 75, 125 ...
    initial begin
        clk = 1'b0;
        forever #25 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Apply inputs, then move to 1 ns past the next rising edge.
    task automatic step(input logic i_rst, input logic i_sclr, input logic i_en,
                        input logic [7:0] i_d);
        rst  = i_rst;
        sclr = i_sclr;
        en   = i_en;
        d    = i_d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst  = 1'b0;
        sclr = 1'b0;
        en   = 1'b1;
        d    = 8'hFF;

        step(1'b0, 1'b0, 1'b1, 8'hFF);
        chk("load_ff_def", q_def, 8'hFF);
        chk("load_ff_alt", q_alt, 8'hFF);

        step(1'b0, 1'b0, 1'b1, 8'h14);
        chk("load_14", q_def, 8'h14);

        step(1'b0, 1'b1, 1'b1, 8'h14);
        chk("sclr_en_def", q_def, 8'h00);
        chk("sclr_en_alt", q_alt, 8'h5A);

        step(1'b0, 1'b0, 1'b1, 8'h33);
        chk("load_33", q_def, 8'h33);

        step(1'b0, 1'b1, 1'b0, 8'h33);
        chk("sclr_noen_def", q_def, 8'h00);
        chk("sclr_noen_alt", q_alt, 8'h5A);

        step(1'b0, 1'b0, 1'b1, 8'h0F);
        chk("load_0f", q_def, 8'h0F);

        step(1'b0, 1'b0, 1'b0, 8'hAA);
        chk("hold_0f_def", q_def, 8'h0F);
        chk("hold_0f_alt", q_alt, 8'h0F);

        step(1'b1, 1'b0, 1'b0, 8'hAA);
        chk("rst_def", q_def, 8'h00);
        chk("rst_alt", q_alt, 8'hA5);

        step(1'b0, 1'b0, 1'b1, 8'h5C);
        chk("resume_5c", q_def, 8'h5C);

        // Pulses that start and end between edges must not disturb q.
        en = 1'b0;
        #5  rst = 1'b1;
        #5  rst = 1'b0;
        #5  sclr = 1'b1;
        #5  sclr = 1'b0;
        #5  begin en = 1'b1; d = 8'h99; end
        #5  begin en = 1'b0; d = 8'hAA; end
        @(posedge clk);
        #1;
        chk("glitch_def", q_def, 8'h5C);
        chk("glitch_alt", q_alt, 8'h5C);

        step(1'b1, 1'b0, 1'b1, 8'h77);
        chk("rst_over_en_def", q_def, 8'h00);
        chk("rst_over_en_alt", q_alt, 8'hA5);

        step(1'b0, 1'b0, 1'b1, 8'h81);
        chk("load_81", q_alt, 8'h81);

        step(1'b1, 1'b1, 1'b1, 8'h77);
        chk("rst_over_sclr_def", q_def, 8'h00);
        chk("rst_over_sclr_alt", q_alt, 8'hA5);

        step(1'b0, 1'b1, 1'b1, 8'h77);
        chk("sclr_after_rst_alt", q_alt, 8'h5A);

        step(1'b0, 1'b0, 1'b1, 8'hC3);
        chk("load_c3_def", q_def, 8'hC3);
        chk("load_c3_alt", q_alt, 8'hC3);

        step(1'b0, 1'b0, 1'b0, 8'h3C);
        chk("hold_c3", q_def, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_reg_dff_sclr
`default_nettype wire
